id_ex_issue: RTL and testbench

- Decode-and-issue stage that produces the execute-stage ALU interface: alu_op, funct3, funct7, operand A and operand B.
- Sits between the IF/ID register and the ALU.
- Decodes one RV32 instruction per cycle, generates immediates and selects operands.
- Holds the ID/EX pipeline register, with stall/flush control and bubble insertion.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/id_ex_issue_if.sv | 33 +++
 rtl/id_ex_issue_imm_gen.sv | 17 +
 rtl/id_ex_issue.sv | 195 +++++++++++++++++++
 tb/tb_id_ex_issue.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants: base opcodes, ALU-op classes and funct7 variants.
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_MEM   = 2'b00;
   localparam logic [1:0] ALUOP_BR    = 2'b01;
   localparam logic [1:0] ALUOP_ARITH = 2'b10;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [2:0] F3_SHIFT_RIGHT = 3'b101;

endpackage

// File: rtl/id_ex_issue_if.sv
// ID/EX register contents as seen by the execute stage; the issue stage drives it.
interface id_ex_issue_if #(
   parameter int data_width     = 32,
   parameter int reg_addr_width = 5
);
   logic                      ex_valid;
   logic [1:0]                ex_alu_op;
   logic [2:0]                ex_funct3;
   logic [6:0]                ex_funct7;
   logic [data_width-1:0]     ex_operand_a;
   logic [data_width-1:0]     ex_operand_b;
   logic [data_width-1:0]     ex_store_data;
   logic [data_width-1:0]     ex_imm;
   logic [data_width-1:0]     ex_pc;
   logic [reg_addr_width-1:0] ex_rd;
   logic                      ex_reg_write;
   logic                      ex_mem_read;
   logic                      ex_mem_write;
   logic                      ex_branch;
   logic                      ex_illegal;

   modport master (
      output ex_valid, ex_alu_op, ex_funct3, ex_funct7, ex_operand_a, ex_operand_b,
             ex_store_data, ex_imm, ex_pc, ex_rd, ex_reg_write, ex_mem_read,
             ex_mem_write, ex_branch, ex_illegal
   );

   modport slave (
      input ex_valid, ex_alu_op, ex_funct3, ex_funct7, ex_operand_a, ex_operand_b,
            ex_store_data, ex_imm, ex_pc, ex_rd, ex_reg_write, ex_mem_read,
            ex_mem_write, ex_branch, ex_illegal
   );
endinterface

// File: rtl/id_ex_issue_imm_gen.sv
// Sign-extended I/S/B immediate extraction; purely combinational so the branch
// unit can share it.
module imm_gen #(
   parameter int data_width = 32
) (
   input  logic [31:0]           instr,
   output logic [data_width-1:0] imm_i,
   output logic [data_width-1:0] imm_s,
   output logic [data_width-1:0] imm_b
);

   assign imm_i = {{(data_width-12){instr[31]}}, instr[31:20]};
   assign imm_s = {{(data_width-12){instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{(data_width-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                   instr[11:8], 1'b0};

endmodule

// File: rtl/id_ex_issue.sv
// Decode/issue stage: decodes the IF/ID instruction, selects ALU operands and
// holds the ID/EX register with flush > stall > load priority.
module id_ex_issue
   import riscv_pkg::*;
#(
   parameter int data_width     = 32,
   parameter int reg_addr_width = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      if_valid,
   input  logic [31:0]               if_instr,
   input  logic [data_width-1:0]     if_pc,
   output logic [reg_addr_width-1:0] rs1_addr,
   output logic [reg_addr_width-1:0] rs2_addr,
   input  logic [data_width-1:0]     rs1_data,
   input  logic [data_width-1:0]     rs2_data,
   input  logic                      stall,
   input  logic                      flush,
   id_ex_issue_if.master             ex
);

   logic [data_width-1:0] imm_i, imm_s, imm_b;
   logic [reg_addr_width-1:0] dec_rd;

   logic                      valid_q, valid_d;
   logic [1:0]                alu_op_q, alu_op_d;
   logic [2:0]                funct3_q, funct3_d;
   logic [6:0]                funct7_q, funct7_d;
   logic [data_width-1:0]     operand_a_q, operand_a_d;
   logic [data_width-1:0]     operand_b_q, operand_b_d;
   logic [data_width-1:0]     store_data_q, store_data_d;
   logic [data_width-1:0]     imm_q, imm_d;
   logic [data_width-1:0]     pc_q, pc_d;
   logic [reg_addr_width-1:0] rd_q, rd_d;
   logic                      reg_write_q, reg_write_d;
   logic                      mem_read_q, mem_read_d;
   logic                      mem_write_q, mem_write_d;
   logic                      branch_q, branch_d;
   logic                      illegal_q, illegal_d;

   assign rs1_addr = reg_addr_width'(if_instr[19:15]);
   assign rs2_addr = reg_addr_width'(if_instr[24:20]);
   assign dec_rd   = reg_addr_width'(if_instr[11:7]);

   imm_gen #(.data_width(data_width)) u_imm_gen (
      .instr (if_instr),
      .imm_i (imm_i),
      .imm_s (imm_s),
      .imm_b (imm_b)
   );

   // Next ID/EX contents: hold on stall, bubble on flush/invalid/illegal, else decode.
   always_comb begin
      valid_d      = valid_q;
      alu_op_d     = alu_op_q;
      funct3_d     = funct3_q;
      funct7_d     = funct7_q;
      operand_a_d  = operand_a_q;
      operand_b_d  = operand_b_q;
      store_data_d = store_data_q;
      imm_d        = imm_q;
      pc_d         = pc_q;
      rd_d         = rd_q;
      reg_write_d  = reg_write_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      branch_d     = branch_q;
      illegal_d    = illegal_q;

      if (flush || !stall) begin
         valid_d      = 1'b0;
         alu_op_d     = ALUOP_MEM;
         funct3_d     = '0;
         funct7_d     = F7_BASE;
         operand_a_d  = '0;
         operand_b_d  = '0;
         store_data_d = '0;
         imm_d        = '0;
         pc_d         = '0;
         rd_d         = '0;
         reg_write_d  = 1'b0;
         mem_read_d   = 1'b0;
         mem_write_d  = 1'b0;
         branch_d     = 1'b0;
         illegal_d    = 1'b0;
      end

      if (!flush && !stall && if_valid) begin
         valid_d     = 1'b1;
         pc_d        = if_pc;
         funct3_d    = if_instr[14:12];
         operand_a_d = rs1_data;
         case (if_instr[6:0])
            OP_R: begin
               alu_op_d    = ALUOP_ARITH;
               funct7_d    = if_instr[31:25];
               operand_b_d = rs2_data;
               rd_d        = dec_rd;
               reg_write_d = (dec_rd != '0);
            end
            OP_IMM: begin
               alu_op_d    = ALUOP_ARITH;
               funct7_d    = (if_instr[14:12] == F3_SHIFT_RIGHT) ? if_instr[31:25] : F7_BASE;
               operand_b_d = imm_i;
               imm_d       = imm_i;
               rd_d        = dec_rd;
               reg_write_d = (dec_rd != '0);
            end
            OP_LOAD: begin
               alu_op_d    = ALUOP_MEM;
               operand_b_d = imm_i;
               imm_d       = imm_i;
               rd_d        = dec_rd;
               reg_write_d = (dec_rd != '0);
               mem_read_d  = 1'b1;
            end
            OP_STORE: begin
               alu_op_d     = ALUOP_MEM;
               operand_b_d  = imm_s;
               imm_d        = imm_s;
               store_data_d = rs2_data;
               mem_write_d  = 1'b1;
            end
            OP_BRANCH: begin
               alu_op_d    = ALUOP_BR;
               operand_b_d = rs2_data;
               imm_d       = imm_b;
               branch_d    = 1'b1;
            end
            default: begin
               valid_d     = 1'b0;
               pc_d        = '0;
               funct3_d    = '0;
               operand_a_d = '0;
               illegal_d   = 1'b1;
            end
         endcase
      end
   end

   // ID/EX pipeline register, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         alu_op_q     <= '0;
         funct3_q     <= '0;
         funct7_q     <= '0;
         operand_a_q  <= '0;
         operand_b_q  <= '0;
         store_data_q <= '0;
         imm_q        <= '0;
         pc_q         <= '0;
         rd_q         <= '0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         branch_q     <= 1'b0;
         illegal_q    <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         alu_op_q     <= alu_op_d;
         funct3_q     <= funct3_d;
         funct7_q     <= funct7_d;
         operand_a_q  <= operand_a_d;
         operand_b_q  <= operand_b_d;
         store_data_q <= store_data_d;
         imm_q        <= imm_d;
         pc_q         <= pc_d;
         rd_q         <= rd_d;
         reg_write_q  <= reg_write_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         branch_q     <= branch_d;
         illegal_q    <= illegal_d;
      end
   end

   assign ex.ex_valid      = valid_q;
   assign ex.ex_alu_op     = alu_op_q;
   assign ex.ex_funct3     = funct3_q;
   assign ex.ex_funct7     = funct7_q;
   assign ex.ex_operand_a  = operand_a_q;
   assign ex.ex_operand_b  = operand_b_q;
   assign ex.ex_store_data = store_data_q;
   assign ex.ex_imm        = imm_q;
   assign ex.ex_pc         = pc_q;
   assign ex.ex_rd         = rd_q;
   assign ex.ex_reg_write  = reg_write_q;
   assign ex.ex_mem_read   = mem_read_q;
   assign ex.ex_mem_write  = mem_write_q;
   assign ex.ex_branch     = branch_q;
   assign ex.ex_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// Bench for id_ex_issue: directed scenarios followed by randomized traffic,
// compared against an instruction-level reference model.
module tb_id_ex_issue;

   typedef struct packed {
      logic        valid;
      logic [1:0]  alu_op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sd;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        br;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_valid = 1'b0;
   logic [31:0] if_instr = '0;
   logic [31:0] if_pc = '0;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;

   int   pass_cnt = 0;
   int   check_cnt = 0;
   int   fail_cnt = 0;
   exp_t exp_s = '0;

   id_ex_issue_if #(.data_width(32), .reg_addr_width(5)) ex_if ();

   id_ex_issue #(.data_width(32), .reg_addr_width(5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_valid (if_valid),
      .if_instr (if_instr),
      .if_pc    (if_pc),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .stall    (stall),
      .flush    (flush),
      .ex       (ex_if.master)
   );

   always #5 clk = ~clk;

   // Instruction-level meaning of one RV32 word, written from the ISA rules.
   function automatic exp_t refDecode(input logic v, input logic [31:0] ins,
                                      input logic [31:0] pc, input logic [31:0] r1,
                                      input logic [31:0] r2);
      exp_t e;
      logic [31:0] iimm, simm, bimm;
      e = '0;
      iimm = ins[31:20];
      if (ins[31]) iimm = iimm - 32'd4096;
      simm = ins[31:25] * 32 + ins[11:7];
      if (ins[31]) simm = simm - 32'd4096;
      bimm = ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
      if (ins[31]) bimm = bimm - 32'd8192;
      if (!v) return e;
      if (ins[6:0] == 7'b0110011) begin
         e.valid = 1; e.alu_op = 2'b10; e.f3 = ins[14:12]; e.f7 = ins[31:25];
         e.a = r1; e.b = r2; e.pc = pc; e.rd = ins[11:7]; e.rw = (ins[11:7] != 0);
      end else if (ins[6:0] == 7'b0010011) begin
         e.valid = 1; e.alu_op = 2'b10; e.f3 = ins[14:12];
         e.f7 = (ins[14:12] == 3'd5) ? ins[31:25] : 7'd0;
         e.a = r1; e.b = iimm; e.imm = iimm; e.pc = pc; e.rd = ins[11:7];
         e.rw = (ins[11:7] != 0);
      end else if (ins[6:0] == 7'b0000011) begin
         e.valid = 1; e.alu_op = 2'b00; e.f3 = ins[14:12];
         e.a = r1; e.b = iimm; e.imm = iimm; e.pc = pc; e.rd = ins[11:7];
         e.rw = (ins[11:7] != 0); e.mr = 1;
      end else if (ins[6:0] == 7'b0100011) begin
         e.valid = 1; e.alu_op = 2'b00; e.f3 = ins[14:12];
         e.a = r1; e.b = simm; e.imm = simm; e.sd = r2; e.pc = pc; e.mw = 1;
      end else if (ins[6:0] == 7'b1100011) begin
         e.valid = 1; e.alu_op = 2'b01; e.f3 = ins[14:12];
         e.a = r1; e.b = r2; e.imm = bimm; e.pc = pc; e.br = 1;
      end else begin
         e.ill = 1;
      end
      return e;
   endfunction

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      check_cnt++;
      assert (obs === expv) pass_cnt++;
      else begin
         fail_cnt++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic checkOutput(input string step);
      cmp({step, ".valid"},  32'(ex_if.ex_valid),      32'(exp_s.valid));
      cmp({step, ".alu_op"}, 32'(ex_if.ex_alu_op),     32'(exp_s.alu_op));
      cmp({step, ".funct3"}, 32'(ex_if.ex_funct3),     32'(exp_s.f3));
      cmp({step, ".funct7"}, 32'(ex_if.ex_funct7),     32'(exp_s.f7));
      cmp({step, ".op_a"},   ex_if.ex_operand_a,       exp_s.a);
      cmp({step, ".op_b"},   ex_if.ex_operand_b,       exp_s.b);
      cmp({step, ".sdata"},  ex_if.ex_store_data,      exp_s.sd);
      cmp({step, ".imm"},    ex_if.ex_imm,             exp_s.imm);
      cmp({step, ".pc"},     ex_if.ex_pc,              exp_s.pc);
      cmp({step, ".rd"},     32'(ex_if.ex_rd),         32'(exp_s.rd));
      cmp({step, ".rw"},     32'(ex_if.ex_reg_write),  32'(exp_s.rw));
      cmp({step, ".mr"},     32'(ex_if.ex_mem_read),   32'(exp_s.mr));
      cmp({step, ".mw"},     32'(ex_if.ex_mem_write),  32'(exp_s.mw));
      cmp({step, ".br"},     32'(ex_if.ex_branch),     32'(exp_s.br));
      cmp({step, ".ill"},    32'(ex_if.ex_illegal),    32'(exp_s.ill));
      cmp({step, ".rs1a"},   32'(rs1_addr),            32'(if_instr[19:15]));
      cmp({step, ".rs2a"},   32'(rs2_addr),            32'(if_instr[24:20]));
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then check.
   task automatic applyStimulus(input string step, input logic v, input logic [31:0] ins,
                                input logic [31:0] pc, input logic [31:0] r1,
                                input logic [31:0] r2, input logic st, input logic fl);
      if_valid = v; if_instr = ins; if_pc = pc;
      rs1_data = r1; rs2_data = r2; stall = st; flush = fl;
      @(posedge clk);
      if (fl)       exp_s = '0;
      else if (!st) exp_s = refDecode(v, ins, pc, r1, r2);
      #1;
      checkOutput(step);
   endtask

   initial begin
      logic [6:0]  ops [7];
      logic [31:0] rnd;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'h7F, 7'h37};

      #3;
      exp_s = '0;
      checkOutput("por");
      #9 rst_n = 1'b1;

      applyStimulus("add", 1, 32'h002081B3, 32'h100, 5, 7, 0, 0);
      cmp("add.lit_b", ex_if.ex_operand_b, 32'd7);
      cmp("add.lit_rd", 32'(ex_if.ex_rd), 32'd3);
      applyStimulus("sub", 1, 32'h402081B3, 32'h104, 5, 7, 0, 0);
      cmp("sub.lit_f7", 32'(ex_if.ex_funct7), 32'h20);
      applyStimulus("addi", 1, 32'h40008213, 32'h108, 9, 3, 0, 0);
      cmp("addi.lit_f7", 32'(ex_if.ex_funct7), 32'h00);
      cmp("addi.lit_b", ex_if.ex_operand_b, 32'h400);
      applyStimulus("srai", 1, 32'h4030D213, 32'h10C, 9, 3, 0, 0);
      cmp("srai.lit_f7", 32'(ex_if.ex_funct7), 32'h20);
      cmp("srai.lit_b", ex_if.ex_operand_b, 32'h403);
      applyStimulus("lw", 1, 32'h0080A283, 32'h110, 32'h1000, 3, 0, 0);
      cmp("lw.lit_mr", 32'(ex_if.ex_mem_read), 32'd1);
      applyStimulus("sw", 1, 32'hFE20AE23, 32'h114, 32'h1000, 32'hCAFE, 0, 0);
      cmp("sw.lit_b", ex_if.ex_operand_b, 32'hFFFFFFFC);
      cmp("sw.lit_sd", ex_if.ex_store_data, 32'hCAFE);
      applyStimulus("beq", 1, 32'hFE208EE3, 32'h118, 4, 4, 0, 0);
      cmp("beq.lit_imm", ex_if.ex_imm, 32'hFFFFFFFC);

      applyStimulus("st_add", 1, 32'h002081B3, 32'h200, 11, 22, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus("stall", 1, 32'h0080A283 + 32'(i << 7), 32'h300, 77, 88, 1, 0);
         cmp("stall.lit_a", ex_if.ex_operand_a, 32'd11);
      end
      applyStimulus("st_fl", 1, 32'h002081B3, 32'h204, 1, 2, 1, 1);
      cmp("st_fl.lit_valid", 32'(ex_if.ex_valid), 32'd0);
      applyStimulus("x0add", 1, 32'h00208033, 32'h208, 1, 2, 0, 0);

      applyStimulus("ill", 1, 32'h0000007F, 32'h20C, 1, 2, 0, 0);
      cmp("ill.lit", 32'(ex_if.ex_illegal), 32'd1);
      applyStimulus("ill_next", 1, 32'h002081B3, 32'h210, 3, 4, 0, 0);
      cmp("ill_next.lit", 32'(ex_if.ex_illegal), 32'd0);
      applyStimulus("ill_st", 1, 32'h0000007F, 32'h214, 1, 2, 0, 0);
      applyStimulus("ill_hold", 1, 32'h002081B3, 32'h218, 1, 2, 1, 0);
      cmp("ill_hold.lit", 32'(ex_if.ex_illegal), 32'd1);
      applyStimulus("novalid", 0, 32'h002081B3, 32'h21C, 1, 2, 0, 0);

      applyStimulus("pre_rst", 1, 32'h002081B3, 32'h220, 6, 8, 0, 0);
      cmp("pre_rst.valid", 32'(ex_if.ex_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      exp_s = '0;
      checkOutput("midrst");
      #2 rst_n = 1'b1;

      for (int i = 0; i < 300; i++) begin
         logic v, st, fl;
         rnd = $urandom();
         rnd[6:0] = ops[$urandom_range(0, 6)];
         v  = ($urandom_range(0, 99) < 85);
         st = ($urandom_range(0, 99) < 20);
         fl = ($urandom_range(0, 99) < 10);
         applyStimulus($sformatf("rnd%0d", i), v, rnd, $urandom(), $urandom(), $urandom(),
                       st, fl);
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
